// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store RMW adapter.
`timescale 1ns/1ps
package lsu_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  // Access size encoding carried on req_size.
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_MRG,
    S_WR,
    S_RSP
  } state_t;

  // A request is rejected when its size is reserved or its address is not
  // naturally aligned to that size.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return (addr_lo != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_unit.sv
// Lane steering for one memory word: extracts/extends a load value and
// merges store data into the selected lane(s).
`timescale 1ns/1ps
module lsu_lane_unit
  import lsu_pkg::*;
(
  input  logic [DATA_W-1:0] i_word,
  input  logic [1:0]        i_addr_lo,
  input  logic [1:0]        i_size,
  input  logic              i_signed,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_load,
  output logic [DATA_W-1:0] o_merged
);

  logic [4:0]        w_shamt;
  logic [DATA_W-1:0] w_shifted;
  logic [DATA_W-1:0] w_lane_mask;
  logic [DATA_W-1:0] w_lane_data;

  // Byte offset within the word expressed as a bit shift.
  assign w_shamt   = {i_addr_lo, 3'b000};
  assign w_shifted = i_word >> w_shamt;

  // Load path: right-align the selected lane(s) and extend.
  always_comb begin
    // NOTE: every variable written in a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    o_load = i_word;
    case (i_size)
      SZ_BYTE: o_load = {{24{i_signed & w_shifted[7]}}, w_shifted[7:0]};
      SZ_HALF: o_load = {{16{i_signed & w_shifted[15]}}, w_shifted[15:0]};
      default: o_load = i_word;
    endcase
  end

  // Store path: replace the selected lane(s) of the read word with wdata.
  always_comb begin
    w_lane_mask = '1;
    w_lane_data = i_wdata;
    case (i_size)
      SZ_BYTE: begin
        w_lane_mask = 32'h0000_00FF << w_shamt;
        w_lane_data = {24'd0, i_wdata[7:0]} << w_shamt;
      end
      SZ_HALF: begin
        w_lane_mask = 32'h0000_FFFF << w_shamt;
        w_lane_data = {16'd0, i_wdata[15:0]} << w_shamt;
      end
      default: begin
        w_lane_mask = '1;
        w_lane_data = i_wdata;
      end
    endcase
    o_merged = (i_word & ~w_lane_mask) | (w_lane_data & w_lane_mask);
  end

endmodule

// File: rtl/lsu_rmw_adapter.sv
// Load/store adapter in front of a word-only data memory. Sub-word stores
// become read-modify-write; loads become word read plus lane extraction.
`timescale 1ns/1ps
module lsu_rmw_adapter
  import lsu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  state_t r_state;
  state_t w_next;

  // Latched request fields.
  logic              r_write;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [1:0]        r_addr_lo;
  logic [DATA_W-1:0] r_wdata;

  // Registered outputs.
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic              r_rsp_err;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_we;
  logic              r_mem_re;
  logic [DATA_W-1:0] r_mem_wd;

  logic              w_accept;
  logic              w_err;
  logic [DATA_W-1:0] w_load;
  logic [DATA_W-1:0] w_merged;

  // r_req_ready is only ever high in IDLE, so it doubles as the accept qualifier.
  assign w_accept = r_req_ready & req_valid;
  assign w_err    = misaligned(req_size, req_addr[1:0]);

  lsu_lane_unit u_lane (
    .i_word    (mem_rd),
    .i_addr_lo (r_addr_lo),
    .i_size    (r_size),
    .i_signed  (r_signed),
    .i_wdata   (r_wdata),
    .o_load    (w_load),
    .o_merged  (w_merged)
  );

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_err)                               w_next = S_RSP;
          else if (req_write && req_size == SZ_WORD) w_next = S_WR;
          else                                     w_next = S_RD;
        end
      end
      S_RD:    w_next = S_MRG;
      S_MRG:   w_next = r_write ? S_WR : S_RSP;
      S_WR:    w_next = S_RSP;
      S_RSP:   w_next = rsp_ready ? S_IDLE : S_RSP;
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Request latch, datapath and registered outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write     <= 1'b0;
      r_size      <= SZ_BYTE;
      r_signed    <= 1'b0;
      r_addr_lo   <= 2'b00;
      r_wdata     <= '0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
      r_mem_wd    <= '0;
    end else begin
      r_req_ready <= (w_next == S_IDLE);
      r_rsp_valid <= (w_next == S_RSP);
      r_mem_re    <= (w_next == S_RD);
      r_mem_we    <= (w_next == S_WR);

      if (w_accept) begin
        r_write    <= req_write;
        r_size     <= req_size;
        r_signed   <= req_signed;
        r_addr_lo  <= req_addr[1:0];
        r_wdata    <= req_wdata;
        r_mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
        r_rsp_err  <= w_err;
        if (w_err)            r_rsp_rdata <= '0;
        if (w_next == S_WR)   r_mem_wd    <= req_wdata;
      end

      // Read data is valid in MRG: either finish the load or build the merged word.
      if (r_state == S_MRG) begin
        if (r_write) r_mem_wd    <= w_merged;
        else         r_rsp_rdata <= w_load;
      end

      // A store reports the full word it wrote.
      if (r_state == S_WR) r_rsp_rdata <= r_mem_wd;
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;
  assign mem_addr  = r_mem_addr;
  assign mem_we    = r_mem_we;
  assign mem_re    = r_mem_re;
  assign mem_wd    = r_mem_wd;

endmodule

// File: tb/tb_lsu_rmw_adapter.sv
// Self-checking bench: directed scenarios plus random traffic compared
// against a byte-array reference model of the memory.
`timescale 1ns/1ps
module tb_lsu_rmw_adapter;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  int errors = 0;
  int checks = 0;

  lsu_rmw_adapter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-organised memory with registered read, as seen by the adapter.
  logic [31:0] mem [64];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:2]] <= mem_wd;
    if (mem_re) mem_rd <= mem[mem_addr[7:2]];
  end

  // Memory-port monitor: running counts sampled mid-cycle.
  int          we_cnt = 0;
  int          re_cnt = 0;
  int          both_cnt = 0;
  logic [7:0]  last_we_addr = '0;
  logic [31:0] last_wd = '0;
  always @(negedge clk) begin
    if (mem_we) begin
      we_cnt       <= we_cnt + 1;
      last_we_addr <= mem_addr;
      last_wd      <= mem_wd;
    end
    if (mem_re)           re_cnt   <= re_cnt + 1;
    if (mem_re && mem_we) both_cnt <= both_cnt + 1;
  end

  // Reference model: flat little-endian byte array.
  logic [7:0] ref_mem [256];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic ref_access(input logic wr, input logic [1:0] sz, input logic sgn,
                            input logic [7:0] a, input logic [31:0] wd,
                            output logic err, output logic [31:0] rd);
    int nbytes;
    int base;
    logic [31:0] v;
    err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
    rd  = '0;
    if (!err) begin
      nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      base   = int'(a) & ~3;
      if (wr) begin
        for (int i = 0; i < nbytes; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
        for (int i = 0; i < 4; i++) rd[8*i +: 8] = ref_mem[base + i];
      end else begin
        v = '0;
        for (int i = 0; i < nbytes; i++) v[8*i +: 8] = ref_mem[int'(a) + i];
        if (sgn && nbytes < 4 && v[8*nbytes-1])
          for (int b = 8*nbytes; b < 32; b++) v[b] = 1'b1;
        rd = v;
      end
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({pfx, "_rsp_err"},   32'(rsp_err),   32'd0);
    check({pfx, "_rsp_rdata"}, rsp_rdata,      32'd0);
    check({pfx, "_mem_we"},    32'(mem_we),    32'd0);
    check({pfx, "_mem_re"},    32'(mem_re),    32'd0);
    check({pfx, "_mem_addr"},  32'(mem_addr),  32'd0);
    check({pfx, "_mem_wd"},    mem_wd,         32'd0);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20 && !req_ready; i++) begin
      @(posedge clk); #1;
    end
    check("req_ready_wait", 32'(req_ready), 32'd1);
  endtask

  // One complete transaction; hold = cycles rsp_valid is seen with rsp_ready low.
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic sgn,
                        input logic [7:0] a, input logic [31:0] wd, input int hold,
                        output logic [31:0] got);
    logic        exp_err;
    logic [31:0] exp_rd;
    int          exp_lat, exp_we, exp_re, lat, we0, re0, both0;
    wait_ready();
    ref_access(wr, sz, sgn, a, wd, exp_err, exp_rd);
    exp_lat = exp_err ? 1 : (wr && sz == 2'd2) ? 2 : !wr ? 3 : 4;
    exp_we  = (wr && !exp_err) ? 1 : 0;
    exp_re  = (!exp_err && !(wr && sz == 2'd2)) ? 1 : 0;
    we0 = we_cnt; re0 = re_cnt; both0 = both_cnt;

    req_valid  = 1'b1;
    req_write  = wr;
    req_size   = sz;
    req_signed = sgn;
    req_addr   = a;
    req_wdata  = wd;
    rsp_ready  = (hold == 0);
    @(posedge clk); #1;
    // Scramble inputs after accept: the adapter must work from latched copies.
    req_valid  = 1'b0;
    req_write  = 1'($urandom);
    req_size   = 2'($urandom);
    req_signed = 1'($urandom);
    req_addr   = 8'($urandom);
    req_wdata  = $urandom;

    lat = 1;
    while (!rsp_valid && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency",   32'(lat),       32'(exp_lat));
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("rsp_err",   32'(rsp_err),   32'(exp_err));
    check("rsp_rdata", rsp_rdata,      exp_rd);
    check("mem_addr",  32'(mem_addr),  32'({a[7:2], 2'b00}));
    got = rsp_rdata;

    for (int i = 1; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_rdata", rsp_rdata,      got);
      check("hold_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("post_valid", 32'(rsp_valid), 32'd0);
    check("post_ready", 32'(req_ready), 32'd1);
    check("we_count",   32'(we_cnt - we0),     32'(exp_we));
    check("re_count",   32'(re_cnt - re0),     32'(exp_re));
    check("re_we_both", 32'(both_cnt - both0), 32'd0);
    if (exp_we == 1) begin
      check("wr_addr", 32'(last_we_addr), 32'({a[7:2], 2'b00}));
      check("wr_data", last_wd,           exp_rd);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] g;
    logic [7:0]  ra;
    logic [1:0]  rsz;
    int          r;
    int          we0;

    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    #2;
    check_reset_outputs("rst");
    #10;
    rst_n = 1'b1;
    #1;
    check("rst_ready_pre", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    check("rst_ready_post", 32'(req_ready), 32'd1);

    // Fill the whole memory through the adapter with word stores.
    for (int w = 0; w < 64; w++) do_req(1'b1, 2'd2, 1'b0, 8'(w * 4), $urandom, 0, g);

    // Directed scenarios.
    do_req(1'b1, 2'd2, 1'b0, 8'h10, 32'hDEADBEEF, 0, g); check("tp_wstore", g, 32'hDEADBEEF);
    do_req(1'b0, 2'd2, 1'b0, 8'h10, 32'h0, 0, g);        check("tp_wload",  g, 32'hDEADBEEF);
    do_req(1'b1, 2'd0, 1'b0, 8'h12, 32'h5A, 0, g);       check("tp_bstore", g, 32'hDE5ABEEF);
    do_req(1'b0, 2'd0, 1'b1, 8'h13, 32'h0, 0, g);        check("tp_sbyte",  g, 32'hFFFFFFDE);
    do_req(1'b0, 2'd0, 1'b0, 8'h13, 32'h0, 0, g);        check("tp_ubyte",  g, 32'h000000DE);
    do_req(1'b0, 2'd1, 1'b1, 8'h10, 32'h0, 0, g);        check("tp_shalf",  g, 32'hFFFFBEEF);
    do_req(1'b0, 2'd1, 1'b0, 8'h11, 32'h0, 0, g);        check("tp_mis_half", g, 32'h0);
    do_req(1'b1, 2'd2, 1'b0, 8'h12, 32'h12345678, 0, g); check("tp_mis_word", g, 32'h0);
    do_req(1'b0, 2'd3, 1'b0, 8'h10, 32'h0, 0, g);        check("tp_rsvd",   g, 32'h0);
    do_req(1'b0, 2'd2, 1'b0, 8'h10, 32'h0, 5, g);        check("tp_hold",   g, 32'hDE5ABEEF);
    do_req(1'b0, 2'd0, 1'b0, 8'h10, 32'h0, 0, g);        check("tp_b2b",    g, 32'h000000EF);

    // Reset while a sub-word store sits in MRG: nothing may be written.
    wait_ready();
    we0 = we_cnt;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 8'h11; req_wdata = 32'h77;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    check("midrst_ready", 32'(req_ready), 32'd0);
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_ready_post", 32'(req_ready), 32'd1);
    check("midrst_no_rsp",     32'(rsp_valid), 32'd0);
    check("midrst_no_we",      32'(we_cnt - we0), 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 8'h10, 32'h0, 0, g); check("midrst_old_word", g, 32'hDE5ABEEF);

    // Random traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      ra  = 8'($urandom);
      r   = $urandom_range(0, 9);
      rsz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      if ($urandom_range(0, 3) != 0) begin
        if (rsz == 2'd1) ra[0] = 1'b0;
        if (rsz == 2'd2) ra[1:0] = 2'b00;
      end
      do_req(1'($urandom), rsz, 1'($urandom), ra, $urandom, $urandom_range(0, 3), g);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
